barrel_shift_pipe: RTL and testbench
====================================

Name: barrel_shift_pipe

Overview:
Parametrised, pipelined successor to the 16-bit combinational rotate-right barrel shifter.
- Supports WIDTH-bit operands (power of two).
- Four modes: rotate right, rotate left, logical shift right, arithmetic shift right.
- One register stage per log2 shift level.
- Valid/ready handshake on input and output, with full backpressure.
- Sits between the register file and the writeback of the team's datapath; one result accepted per cycle at full throughput.

Parameters:
WIDTH, 16, operand width in bits; power of two, minimum 4.
SHW, $clog2(WIDTH), shift-amount width; derived, never overridden.
STAGES, SHW, number of pipeline stages (= latency in cycles); fixed equal to SHW.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
A  input  WIDTH  operand
C  input  SHW  shift/rotate amount, 0..WIDTH-1
MODE  input  2  00=ROR, 01=ROL, 10=LSR, 11=ASR
in_valid  input  1  A/C/MODE valid this cycle
in_ready  output  1  block accepts input this cycle
O  output  WIDTH  result
out_valid  output  1  O valid
out_ready  input  1  consumer accepts O
occ  output  SHW+1  number of valid operations in flight (0..STAGES)

Behaviour:
- One clock; reset is asynchronous and active-low: rst_n low immediately clears every stage valid bit, data and amount registers. O=0, out_valid=0, occ=0; in_ready=1 once rst_n is high.
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Stall rule: stall = out_valid && !out_ready. in_ready = !stall.
  - While stalled, every stage register holds, including bubbles. No bubble collapsing.
  - When not stalled, all stages advance one position per cycle.
  - Bubble entry: when no input transfer occurs, stage 0 loads valid=0.
- Latency: an accepted input appears on O with out_valid exactly STAGES cycles later, absent stalls. Each stall cycle adds one cycle.
- Stage k (k=0..SHW-1) applies distance 2^(SHW-1-k) when amount bit SHW-1-k is set; otherwise it passes the data through. Ordering is largest distance first: for WIDTH=16 the stages are 8, 4, 2, 1.
- Each stage register carries: valid, data, remaining amount bits, MODE, fill bit.
- Per-mode result:
  - ROR: O = A rotated right by C.
  - ROL: O = A rotated left by C. Implemented as bit-reverse of A at entry, right rotate, then bit-reverse at exit; the result must equal the rotate-left definition.
  - LSR: zeros fill the vacated MSBs.
  - ASR: vacated MSBs are filled with A[WIDTH-1], captured at stage 0 and carried down the pipe.
- C=0 in any mode: O=A.
- C=WIDTH-1:
  - ROR: O = {A[WIDTH-2:0], A[WIDTH-1]}.
  - LSR: O = {zeros, A[WIDTH-1]}.
- occ:
  - +1 on an input transfer without an output transfer.
  - -1 on an output transfer without an input transfer.
  - Unchanged when both or neither occur.
  - Never exceeds STAGES.
- Simultaneous input and output transfer in the same cycle is legal and sustains full throughput.
- O holds its value while out_valid && !out_ready. O is don't-care when out_valid=0, but is registered, never combinational from A.
- Reset asserted mid-operation: all in-flight results are discarded; no partial result is ever presented after release.

Decomposition:
- Package barrel_pkg holds:
  - mode localparams MODE_ROR=2'b00, MODE_ROL=2'b01, MODE_LSR=2'b10, MODE_ASR=2'b11;
  - the bit-reverse function.
- Sub-module barrel_stage: one registered stage, parametrised by WIDTH and DIST.
  - Inputs: valid/data/amount/mode/fill, plus the stall enable.
  - Performs a conditional right rotate or fill-shift by DIST.
  - Instantiated SHW times via generate by the top level, which also owns the handshake logic and occ.

Test Plan:
1. Latency: WIDTH=16, ROR, A=0x1234, C=4, out_ready=1 -> O=0x4123, out_valid rises exactly 4 cycles after acceptance.
2. ROL and ASR: ROL A=0x8001, C=1 -> O=0x0003. Then ASR A=0x8000, C=3 -> O=0xF000. Then LSR A=0x8000, C=15 -> O=0x0001. All three issued back-to-back; results arrive on consecutive cycles in order.
3. Backpressure: stream 6 ops with out_ready=0 -> in_ready drops once the first result reaches O; occ saturates at 4; O stays stable. Raise out_ready -> all results drain in order with none lost or duplicated.
4. Reset mid-flight: 3 ops in flight, pulse rst_n low asynchronously mid-cycle -> out_valid=0, occ=0 immediately; no stale result after release.
5. Boundaries: C=0 in all modes -> O=A. ROR C=15, A=0x0001 -> O=0x0002. ASR A=0x7FFF, C=15 -> O=0x0000.
6. WIDTH=32 instance, random A/C/MODE for 10k ops with random out_ready -> every O matches the reference model; latency is 5 cycles when unstalled.

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared mode encodings and the bit-reverse helper for the pipelined barrel shifter.
package barrel_pkg;

   localparam logic [1:0] MODE_ROR = 2'b00;
   localparam logic [1:0] MODE_ROL = 2'b01;
   localparam logic [1:0] MODE_LSR = 2'b10;
   localparam logic [1:0] MODE_ASR = 2'b11;

   localparam int MAX_W = 64;

   // Reverses the low w bits of x; bits at and above w come back as zero.
   function automatic logic [MAX_W-1:0] bit_rev(input logic [MAX_W-1:0] x, input int w);
      logic [MAX_W-1:0] r;
      logic [MAX_W-1:0] t;
      r = '0;
      t = x;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < w) begin
            r = {r[MAX_W-2:0], t[0]};
            t = t >> 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/barrel_stage.sv
// One registered shifter level: rotates right or fill-shifts right by DIST when its amount bit is set.
module barrel_stage
   import barrel_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIST = 8,
   localparam int SHW = $clog2(WIDTH),
   localparam int BIT = $clog2(DIST)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             prev_valid,
   input  logic [WIDTH-1:0] prev_data,
   input  logic [SHW-1:0]   prev_amount,
   input  logic [1:0]       prev_mode,
   input  logic             prev_fill,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [SHW-1:0]   amount,
   output logic [1:0]       mode,
   output logic             fill
);

   logic [WIDTH-1:0] shifted;

   // ROL shares the right-rotate path; its operand was bit-reversed on entry.
   always_comb begin
      shifted = prev_data;
      if (prev_amount[BIT]) begin
         if (prev_mode == MODE_ROR || prev_mode == MODE_ROL)
            shifted = {prev_data[DIST-1:0], prev_data[WIDTH-1:DIST]};
         else
            shifted = {{DIST{prev_fill}}, prev_data[WIDTH-1:DIST]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid  <= 1'b0;
         data   <= '0;
         amount <= '0;
         mode   <= MODE_ROR;
         fill   <= 1'b0;
      end else if (en) begin
         valid  <= prev_valid;
         data   <= shifted;
         amount <= prev_amount;
         mode   <= prev_mode;
         fill   <= prev_fill;
      end
   end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined WIDTH-bit barrel shifter (ROR/ROL/LSR/ASR), one level per stage, valid/ready with full backpressure.
module barrel_shift_pipe
   import barrel_pkg::*;
#(
   parameter int WIDTH = 16,
   localparam int SHW = $clog2(WIDTH),
   localparam int STAGES = SHW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [SHW-1:0]   C,
   input  logic [1:0]       MODE,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] O,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SHW:0]     occ
);

   logic stall;
   logic advance;
   logic in_xfer;
   logic out_xfer;

   // Index 0 is the entry point; index k+1 is the register of stage k.
   logic             st_valid  [STAGES+1];
   logic [WIDTH-1:0] st_data   [STAGES+1];
   logic [SHW-1:0]   st_amount [STAGES+1];
   logic [1:0]       st_mode   [STAGES+1];
   logic             st_fill   [STAGES+1];

   assign stall    = out_valid && !out_ready;
   assign advance  = !stall;
   assign in_ready = !stall;
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   assign st_valid[0]  = in_xfer;
   assign st_data[0]   = (MODE == MODE_ROL) ? WIDTH'(bit_rev(MAX_W'(A), WIDTH)) : A;
   assign st_amount[0] = C;
   assign st_mode[0]   = MODE;
   assign st_fill[0]   = (MODE == MODE_ASR) && A[WIDTH-1];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      barrel_stage #(
         .WIDTH (WIDTH),
         .DIST  (1 << (SHW - 1 - k))
      ) u_stage (
         .clk         (clk),
         .rst_n       (rst_n),
         .en          (advance),
         .prev_valid  (st_valid[k]),
         .prev_data   (st_data[k]),
         .prev_amount (st_amount[k]),
         .prev_mode   (st_mode[k]),
         .prev_fill   (st_fill[k]),
         .valid       (st_valid[k+1]),
         .data        (st_data[k+1]),
         .amount      (st_amount[k+1]),
         .mode        (st_mode[k+1]),
         .fill        (st_fill[k+1])
      );
   end

   assign out_valid = st_valid[STAGES];
   assign O = (st_mode[STAGES] == MODE_ROL) ? WIDTH'(bit_rev(MAX_W'(st_data[STAGES]), WIDTH))
                                            : st_data[STAGES];

   // The last stage still carries amount/fill for uniformity; nothing downstream needs them.
   logic unused_tail;
   assign unused_tail = ^{st_amount[STAGES], st_fill[STAGES]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         occ <= '0;
      else if (in_xfer && !out_xfer)
         occ <= occ + (SHW+1)'(1);
      else if (out_xfer && !in_xfer)
         occ <= occ - (SHW+1)'(1);
   end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Bench for barrel_shift_pipe: 16-bit directed scenarios plus random streams on 16- and 32-bit instances.
module tb_barrel_shift_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst16, iv16, rdy16, ov16, or16;
   logic [15:0] a16, o16;
   logic [3:0]  c16;
   logic [1:0]  m16;
   logic [4:0]  occ16;

   logic        rst32, iv32, rdy32, ov32, or32;
   logic [31:0] a32, o32;
   logic [4:0]  c32;
   logic [1:0]  m32;
   logic [5:0]  occ32;

   barrel_shift_pipe #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst16), .A(a16), .C(c16), .MODE(m16), .in_valid(iv16),
      .in_ready(rdy16), .O(o16), .out_valid(ov16), .out_ready(or16), .occ(occ16));

   barrel_shift_pipe #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst32), .A(a32), .C(c32), .MODE(m32), .in_valid(iv32),
      .in_ready(rdy32), .O(o32), .out_valid(ov32), .out_ready(or32), .occ(occ32));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result straight from the mode definitions.
   function automatic logic [63:0] model(input logic [63:0] a, input int c, input int m, input int w);
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      case (m)
         0:       return ((a >> c) | (a << (w - c))) & mask;
         1:       return ((a << c) | (a >> (w - c))) & mask;
         2:       return a >> c;
         default: return (((a >> (w - 1)) & 64'd1) != 0) ? ((a >> c) | (mask & ~(mask >> c))) : (a >> c);
      endcase
   endfunction

   typedef struct {
      logic [63:0] exp;
      int          acc_cyc;
      int          acc_stall;
   } exp_t;

   exp_t        sb [2][$];
   int          cyc [2];
   int          stall_cnt [2];
   bit          head_seen [2];
   bit          prev_stall [2];
   logic [63:0] prev_o [2];
   int          outs [2];

   task automatic mon(input int d, input bit rst, input bit iv, input bit ir, input bit ov, input bit ordy,
                      input logic [63:0] a, input logic [63:0] o, input int c, input int m,
                      input int occ, input int w, input int stages);
      string pfx;
      bit    stall;
      exp_t  e;
      pfx = (d == 0) ? "w16_" : "w32_";
      cyc[d]++;
      if (!rst) begin
         sb[d].delete();
         head_seen[d]  = 1'b0;
         prev_stall[d] = 1'b0;
         return;
      end
      chk(occ == sb[d].size(), {pfx, "occ"}, 64'(occ), 64'(sb[d].size()));
      chk(ir == !(ov && !ordy), {pfx, "in_ready"}, 64'(ir), 64'(!(ov && !ordy)));
      if (prev_stall[d])
         chk(ov && o == prev_o[d], {pfx, "hold"}, o, prev_o[d]);
      if (ov && !head_seen[d]) begin
         if (sb[d].size() == 0)
            chk(1'b0, {pfx, "spurious_valid"}, 64'(ov), 64'd0);
         else
            chk(cyc[d] - sb[d][0].acc_cyc == stages + stall_cnt[d] - sb[d][0].acc_stall, {pfx, "latency"},
                64'(cyc[d] - sb[d][0].acc_cyc), 64'(stages + stall_cnt[d] - sb[d][0].acc_stall));
         head_seen[d] = 1'b1;
      end
      stall = ov && !ordy;
      if (ov && ordy && sb[d].size() != 0) begin
         e = sb[d].pop_front();
         chk(o == e.exp, {pfx, "data"}, o, e.exp);
         head_seen[d] = 1'b0;
         outs[d]++;
      end
      stall_cnt[d] += int'(stall);
      if (iv && ir) begin
         e.exp       = model(a, c, m, w);
         e.acc_cyc   = cyc[d];
         e.acc_stall = stall_cnt[d];
         sb[d].push_back(e);
      end
      prev_stall[d] = stall;
      prev_o[d]     = o;
   endtask

   always @(negedge clk)
      mon(0, rst16, iv16, rdy16, ov16, or16, 64'(a16), 64'(o16), int'(c16), int'(m16), int'(occ16), 16, 4);
   always @(negedge clk)
      mon(1, rst32, iv32, rdy32, ov32, or32, 64'(a32), 64'(o32), int'(c32), int'(m32), int'(occ32), 32, 5);

   task automatic send16(input logic [15:0] a, input logic [3:0] c, input logic [1:0] m);
      int n;
      bit acc;
      n = 0;
      acc = 1'b0;
      a16 = a; c16 = c; m16 = m; iv16 = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = rdy16;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) chk(1'b0, "send16_timeout", 64'(n), 64'd200);
      iv16 = 1'b0;
   endtask

   logic [15:0] b_a [8];
   logic [3:0]  b_c [8];
   logic [1:0]  b_m [8];
   logic [15:0] b_e [8];
   int          b_n;

   // Sends b_* back-to-back and expects the literal results on consecutive cycles.
   task automatic run_batch(input string tag);
      fork
         begin
            for (int i = 0; i < b_n; i++) send16(b_a[i], b_c[i], b_m[i]);
         end
         begin
            int k;
            k = 0;
            while (k < 50) begin
               @(negedge clk);
               if (ov16) break;
               k++;
            end
            chk(ov16, {tag, "_arrive"}, 64'(ov16), 64'd1);
            for (int i = 0; i < b_n; i++) begin
               if (i > 0) @(negedge clk);
               chk(ov16 && o16 == b_e[i], {tag, "_result"}, 64'(o16), 64'(b_e[i]));
            end
         end
      join
   endtask

   task automatic thread16();
      int k;
      int idx;
      int acc;
      int guard;
      logic [15:0] t3_a [6];
      t3_a = '{16'h00F0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

      rst16 = 1'b0; iv16 = 1'b0; or16 = 1'b1; a16 = '0; c16 = '0; m16 = '0;
      #2;
      chk(o16 == 16'h0 && !ov16, "reset_out", 64'(o16), 64'd0);
      chk(occ16 == 5'd0, "reset_occ", 64'(occ16), 64'd0);
      chk(rdy16 == 1'b1, "reset_in_ready", 64'(rdy16), 64'd1);
      #10 rst16 = 1'b1;
      @(posedge clk); #1;

      // Latency and data for a single ROR.
      send16(16'h1234, 4'd4, 2'b00);
      k = 1;
      while (k < 20) begin
         @(negedge clk);
         if (ov16) break;
         k++;
      end
      chk(k == 4, "t1_latency", 64'(k), 64'd4);
      chk(o16 == 16'h4123, "t1_data", 64'(o16), 64'h4123);
      @(posedge clk); #1;

      b_n = 3;
      b_a[0] = 16'h8001; b_c[0] = 4'd1;  b_m[0] = 2'b01; b_e[0] = 16'h0003;
      b_a[1] = 16'h8000; b_c[1] = 4'd3;  b_m[1] = 2'b11; b_e[1] = 16'hF000;
      b_a[2] = 16'h8000; b_c[2] = 4'd15; b_m[2] = 2'b10; b_e[2] = 16'h0001;
      run_batch("t2");
      repeat (3) @(posedge clk);
      #1;

      // Backpressure: only four ops fit while O is blocked.
      or16 = 1'b0;
      idx = 0;
      for (int cy = 0; cy < 12; cy++) begin
         if (idx < 6) begin
            a16 = t3_a[idx]; c16 = 4'd4; m16 = 2'b00; iv16 = 1'b1;
         end else iv16 = 1'b0;
         @(negedge clk);
         if (iv16 && rdy16) idx++;
         @(posedge clk); #1;
      end
      chk(idx == 4, "t3_accepted", 64'(idx), 64'd4);
      chk(occ16 == 5'd4, "t3_occ_sat", 64'(occ16), 64'd4);
      chk(rdy16 == 1'b0, "t3_in_ready_low", 64'(rdy16), 64'd0);
      chk(ov16 && o16 == 16'h000F, "t3_head", 64'(o16), 64'h000F);
      or16 = 1'b1;
      guard = 0;
      while (idx < 6 && guard < 50) begin
         a16 = t3_a[idx]; c16 = 4'd4; m16 = 2'b00; iv16 = 1'b1;
         @(negedge clk);
         if (rdy16) idx++;
         @(posedge clk); #1;
         guard++;
      end
      iv16 = 1'b0;
      guard = 0;
      while ((occ16 != 0 || ov16) && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      chk(occ16 == 5'd0, "t3_drained", 64'(occ16), 64'd0);
      chk(outs[0] == 10, "t3_out_count", 64'(outs[0]), 64'd10);

      // Asynchronous reset with three ops in flight.
      send16(16'hAAAA, 4'd1, 2'b00);
      send16(16'hBBBB, 4'd2, 2'b10);
      send16(16'hCCCC, 4'd3, 2'b11);
      #3 rst16 = 1'b0;
      #2;
      chk(!ov16, "t4_valid_cleared", 64'(ov16), 64'd0);
      chk(occ16 == 5'd0, "t4_occ_cleared", 64'(occ16), 64'd0);
      @(negedge clk);
      @(negedge clk);
      #2 rst16 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk(!ov16, "t4_no_stale", 64'(ov16), 64'd0);
      end
      @(posedge clk); #1;

      b_n = 6;
      b_a[0] = 16'hA5C3; b_c[0] = 4'd0;  b_m[0] = 2'b00; b_e[0] = 16'hA5C3;
      b_a[1] = 16'hA5C3; b_c[1] = 4'd0;  b_m[1] = 2'b01; b_e[1] = 16'hA5C3;
      b_a[2] = 16'hA5C3; b_c[2] = 4'd0;  b_m[2] = 2'b10; b_e[2] = 16'hA5C3;
      b_a[3] = 16'hA5C3; b_c[3] = 4'd0;  b_m[3] = 2'b11; b_e[3] = 16'hA5C3;
      b_a[4] = 16'h0001; b_c[4] = 4'd15; b_m[4] = 2'b00; b_e[4] = 16'h0002;
      b_a[5] = 16'h7FFF; b_c[5] = 4'd15; b_m[5] = 2'b11; b_e[5] = 16'h0000;
      run_batch("t5");

      acc = 0;
      guard = 0;
      while (acc < 2000 && guard < 20000) begin
         iv16 = ($urandom_range(3) != 0);
         a16 = 16'($urandom);
         c16 = 4'($urandom_range(15));
         m16 = 2'($urandom_range(3));
         or16 = ($urandom_range(3) != 0);
         @(negedge clk);
         if (iv16 && rdy16) acc++;
         @(posedge clk); #1;
         guard++;
      end
      chk(acc == 2000, "rand16_accepted", 64'(acc), 64'd2000);
      iv16 = 1'b0; or16 = 1'b1;
      guard = 0;
      while ((occ16 != 0 || ov16) && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      chk(occ16 == 5'd0 && !ov16, "rand16_drained", 64'(occ16), 64'd0);
   endtask

   task automatic thread32();
      int acc;
      int guard;
      rst32 = 1'b0; iv32 = 1'b0; or32 = 1'b1; a32 = '0; c32 = '0; m32 = '0;
      #2;
      chk(o32 == 32'h0 && !ov32 && occ32 == 6'd0, "w32_reset", 64'(o32), 64'd0);
      #10 rst32 = 1'b1;
      @(posedge clk); #1;
      acc = 0;
      guard = 0;
      while (acc < 10000 && guard < 60000) begin
         iv32 = ($urandom_range(3) != 0);
         a32 = $urandom;
         c32 = 5'($urandom_range(31));
         m32 = 2'($urandom_range(3));
         or32 = ($urandom_range(3) != 0);
         @(negedge clk);
         if (iv32 && rdy32) acc++;
         @(posedge clk); #1;
         guard++;
      end
      chk(acc == 10000, "rand32_accepted", 64'(acc), 64'd10000);
      iv32 = 1'b0; or32 = 1'b1;
      guard = 0;
      while ((occ32 != 0 || ov32) && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      chk(occ32 == 6'd0 && !ov32, "rand32_drained", 64'(occ32), 64'd0);
      chk(outs[1] == 10000, "rand32_out_count", 64'(outs[1]), 64'd10000);
   endtask

   initial begin
      chk(model(64'h1234, 4, 0, 16) == 64'h4123, "model_ror", model(64'h1234, 4, 0, 16), 64'h4123);
      chk(model(64'h8001, 1, 1, 16) == 64'h0003, "model_rol", model(64'h8001, 1, 1, 16), 64'h0003);
      chk(model(64'h8000, 3, 3, 16) == 64'hF000, "model_asr", model(64'h8000, 3, 3, 16), 64'hF000);
      chk(model(64'h8000, 15, 2, 16) == 64'h0001, "model_lsr", model(64'h8000, 15, 2, 16), 64'h0001);
      chk(model(64'h0001, 15, 0, 16) == 64'h0002, "model_ror15", model(64'h0001, 15, 0, 16), 64'h0002);
      chk(model(64'h7FFF, 15, 3, 16) == 64'h0000, "model_asr_pos", model(64'h7FFF, 15, 3, 16), 64'h0000);
      chk(model(64'h80000000, 4, 3, 32) == 64'hF8000000, "model_asr32", model(64'h80000000, 4, 3, 32), 64'hF8000000);
      fork
         thread16();
         thread32();
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench did not complete");
   end

endmodule
